pwm_cfgreg_bank: RTL and testbench

Parametrised, multi-channel successor to the single-channel PWM config-word packer. Holds a shadow and an active config set per channel: onoff, mask_mode and count_mode. Shadow values are loaded through a write handshake. Active values are committed glitch-free at each channel's own PWM period boundary (sync_evt). Output is the packed active config word for every channel, and it feeds the PWM counter/comparator channels.

---
 rtl/pwm_cfgreg_bank.sv | 116 +++++++++++
 tb/tb_pwm_cfgreg_bank.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_cfgreg_bank.sv
// pwm_cfgreg_bank: per-channel shadow/active PWM config bank with glitch-free commit at each channel's period boundary.
// Optional commit watchdog with commit_timeout port: define PWM_CFGREG_COMMIT_TIMEOUT_EN.
module pwm_cfgreg_bank #(
    parameter int N_CH = 4,
    parameter int CM_W = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 wr_valid,
    output logic                                 wr_ready,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] wr_ch,
    input  logic                                 wr_onoff,
    input  logic                                 wr_mask,
    input  logic [CM_W-1:0]                      wr_count_mode,
    output logic                                 wr_err,
    input  logic                                 commit_req,
    output logic                                 commit_busy,
    output logic                                 commit_done,
    output logic                                 commit_abort,
    input  logic [N_CH-1:0]                      sync_evt,
    input  logic                                 force_off,
    output logic [N_CH*(CM_W+2)-1:0]             cfg_concat,
    output logic [N_CH-1:0]                      active_onoff
`ifdef PWM_CFGREG_COMMIT_TIMEOUT_EN
    , output logic                               commit_timeout
`endif
);
    localparam int CW = CM_W + 2;
    localparam logic [1:0] IDLE = 2'd0, ARMED = 2'd1, DONE = 2'd2;
    logic [1:0] state, state_n;
    logic [N_CH-1:0] sh_on, sh_mk, act_on, act_mk, pending;
    logic [N_CH-1:0] sh_on_n, sh_mk_n, act_on_n, act_mk_n, pending_n;
    logic [N_CH-1:0] pend_arm, off_arm, apply;
    logic [N_CH-1:0][CM_W-1:0] sh_cm, act_cm, sh_cm_n, act_cm_n;
    logic wr_fire, wr_ok, arm, tmo, tmo_q;
    assign wr_ready = (state == IDLE) && !force_off;
    assign wr_fire = wr_valid && wr_ready;
    assign wr_ok = wr_fire && (int'(wr_ch) < N_CH);
    assign arm = (state == IDLE) && commit_req;
    assign commit_busy = state == ARMED;
    assign commit_done = state == DONE;
    assign active_onoff = act_on;
`ifdef PWM_CFGREG_COMMIT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wd_cnt;
    assign tmo = (state == ARMED) && (|pending) && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign commit_timeout = tmo_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) wd_cnt <= '0;
        else wd_cnt <= (state == ARMED) ? wd_cnt + 1'b1 : '0;
`else
    assign tmo = 1'b0;
`endif
    // The arm-edge snapshot sees the shadow including a write accepted in the same cycle.
    always_comb begin
        sh_on_n = sh_on;
        sh_mk_n = sh_mk;
        sh_cm_n = sh_cm;
        if (wr_ok) begin
            sh_on_n[wr_ch] = wr_onoff;
            sh_mk_n[wr_ch] = wr_mask;
            sh_cm_n[wr_ch] = wr_count_mode;
        end
        for (int i = 0; i < N_CH; i++)
            pend_arm[i] = {sh_on_n[i], sh_mk_n[i], sh_cm_n[i]} != {act_on[i], act_mk[i], act_cm[i]};
        off_arm = act_on & ~sh_on_n;
        apply = arm ? off_arm : (state == ARMED) ? pending & (sync_evt | {N_CH{tmo}}) : '0;
        act_on_n = (act_on & ~apply) | (sh_on_n & apply);
        act_mk_n = (act_mk & ~apply) | (sh_mk_n & apply);
        for (int i = 0; i < N_CH; i++)
            act_cm_n[i] = apply[i] ? sh_cm_n[i] : act_cm[i];
        pending_n = arm ? pend_arm & ~off_arm : (state == ARMED) ? pending & ~apply : '0;
        state_n = arm ? ((|(pend_arm & ~off_arm)) ? ARMED : DONE)
                : (state == ARMED) ? ((tmo || !(|pending)) ? DONE : ARMED) : IDLE;
    end
    always_comb begin
        cfg_concat = '0;
        for (int i = 0; i < N_CH; i++)
            cfg_concat[i*CW +: CW] = {act_on[i], act_mk[i], act_cm[i]};
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            sh_on <= '0;
            sh_mk <= '0;
            sh_cm <= '0;
            act_on <= '0;
            act_mk <= '0;
            act_cm <= '0;
            pending <= '0;
            wr_err <= 1'b0;
            commit_abort <= 1'b0;
            tmo_q <= 1'b0;
        end else if (force_off) begin
            state <= IDLE;
            sh_on <= '0;
            act_on <= '0;
            pending <= '0;
            wr_err <= 1'b0;
            commit_abort <= state == ARMED;
            tmo_q <= 1'b0;
        end else begin
            state <= state_n;
            sh_on <= sh_on_n;
            sh_mk <= sh_mk_n;
            sh_cm <= sh_cm_n;
            act_on <= act_on_n;
            act_mk <= act_mk_n;
            act_cm <= act_cm_n;
            pending <= pending_n;
            wr_err <= wr_fire && !wr_ok;
            commit_abort <= 1'b0;
            tmo_q <= tmo;
        end
endmodule

// File: tb/tb_pwm_cfgreg_bank.sv
// tb_pwm_cfgreg_bank: scoreboard bench; expectations are queued with a target cycle and checked at the falling edge.
module tb_pwm_cfgreg_bank;
    localparam int N_CH = 5;
    localparam int S_CFG = 0, S_ON = 1, S_RDY = 2, S_BUSY = 3, S_DONE = 4, S_ABT = 5, S_ERR = 6, S_TMO = 7;
    logic clk = 0, rst_n = 0;
    logic wr_valid = 0, wr_onoff = 0, wr_mask = 0, commit_req = 0, force_off = 0;
    logic [2:0] wr_ch = '0;
    logic [1:0] wr_count_mode = '0;
    logic [N_CH-1:0] sync_evt = '0;
    logic wr_ready, wr_err, commit_busy, commit_done, commit_abort;
    logic [N_CH*4-1:0] cfg_concat;
    logic [N_CH-1:0] active_onoff;
`ifdef PWM_CFGREG_COMMIT_TIMEOUT_EN
    logic commit_timeout;
`endif
    int cyc = 0, n_checks = 0, n_errors = 0;
    typedef struct {int t; string tag; int sel; logic [31:0] v;} exp_t;
    exp_t sb[$];

    pwm_cfgreg_bank #(.N_CH(N_CH), .CM_W(2), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_ch(wr_ch),
        .wr_onoff(wr_onoff), .wr_mask(wr_mask), .wr_count_mode(wr_count_mode), .wr_err(wr_err),
        .commit_req(commit_req), .commit_busy(commit_busy), .commit_done(commit_done),
        .commit_abort(commit_abort), .sync_evt(sync_evt), .force_off(force_off),
        .cfg_concat(cfg_concat), .active_onoff(active_onoff)
`ifdef PWM_CFGREG_COMMIT_TIMEOUT_EN
        , .commit_timeout(commit_timeout)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] probe(int sel);
        case (sel)
            S_CFG:  return 32'(cfg_concat);
            S_ON:   return 32'(active_onoff);
            S_RDY:  return 32'(wr_ready);
            S_BUSY: return 32'(commit_busy);
            S_DONE: return 32'(commit_done);
            S_ABT:  return 32'(commit_abort);
            S_ERR:  return 32'(wr_err);
`ifdef PWM_CFGREG_COMMIT_TIMEOUT_EN
            S_TMO:  return 32'(commit_timeout);
`endif
            default: return 32'hdead_beef;
        endcase
    endfunction

    always @(negedge clk)
        for (int i = sb.size() - 1; i >= 0; i--)
            if (sb[i].t == cyc) begin
                check(sb[i].tag, probe(sb[i].sel), sb[i].v);
                sb.delete(i);
            end

    task automatic expect_at(int d, string tag, int sel, logic [31:0] v);
        exp_t e;
        e.t = cyc + d; e.tag = tag; e.sel = sel; e.v = v;
        sb.push_back(e);
    endtask

    task automatic tick(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(int ch, logic [3:0] w);
        wr_valid = 1; wr_ch = 3'(ch);
        {wr_onoff, wr_mask, wr_count_mode} = w;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        expect_at(0, "rst_cfg", S_CFG, 0);
        expect_at(0, "rst_rdy", S_RDY, 1);
        expect_at(0, "rst_busy", S_BUSY, 0);
        expect_at(0, "rst_done", S_DONE, 0);
        expect_at(0, "rst_abort", S_ABT, 0);
        expect_at(0, "rst_err", S_ERR, 0);
        expect_at(0, "rst_on", S_ON, 0);
        // sync-wait commit of ch2
        wr(2, 4'b1110);
        tick; wr_valid = 0; commit_req = 1;
        tick; commit_req = 0;
        expect_at(0, "arm_busy", S_BUSY, 1);
        expect_at(0, "arm_rdy", S_RDY, 0);
        expect_at(0, "arm_cfg", S_CFG, 0);
        expect_at(9, "hold_cfg", S_CFG, 0);
        expect_at(9, "hold_busy", S_BUSY, 1);
        expect_at(9, "hold_done", S_DONE, 0);
        tick(10); sync_evt = 5'b00100;
        tick; sync_evt = 0;
        expect_at(0, "sync_cfg", S_CFG, 32'h00e00);
        expect_at(0, "sync_done0", S_DONE, 0);
        expect_at(1, "sync_done1", S_DONE, 1);
        expect_at(2, "sync_done2", S_DONE, 0);
        expect_at(2, "sync_rdy", S_RDY, 1);
        tick(2);
        // write with commit in same cycle; non-pending sync ignored
        wr(0, 4'b1000); commit_req = 1;
        tick; wr_valid = 0; commit_req = 0; sync_evt = 5'b00010;
        expect_at(0, "c0_busy", S_BUSY, 1);
        expect_at(0, "c0_on", S_ON, 32'b00100);
        expect_at(1, "c0_ignore", S_CFG, 32'h00e00);
        tick; sync_evt = 5'b00001;
        tick; sync_evt = 0;
        expect_at(0, "c0_cfg", S_CFG, 32'h00e08);
        expect_at(1, "c0_done", S_DONE, 1);
        tick(2);
        // safe-shutdown of ch0 at arm edge, ch1 waits for sync
        wr(0, 4'b0000);
        tick; wr(1, 4'b0101); commit_req = 1;
        tick; wr_valid = 0; commit_req = 0;
        expect_at(0, "off_cfg", S_CFG, 32'h00e00);
        expect_at(0, "off_on", S_ON, 32'b00100);
        expect_at(0, "off_busy", S_BUSY, 1);
        expect_at(2, "off_wait_done", S_DONE, 0);
        expect_at(2, "off_wait_cfg", S_CFG, 32'h00e00);
        tick(3); sync_evt = 5'b00010;
        tick; sync_evt = 0;
        expect_at(0, "ch1_cfg", S_CFG, 32'h00e50);
        expect_at(0, "ch1_done0", S_DONE, 0);
        expect_at(1, "ch1_done1", S_DONE, 1);
        tick(2);
        // out-of-range channel write
        wr(5, 4'b1111);
        expect_at(0, "oor_rdy", S_RDY, 1);
        expect_at(1, "oor_err", S_ERR, 1);
        expect_at(1, "oor_cfg", S_CFG, 32'h00e50);
        tick; wr_valid = 0; commit_req = 1;
        tick; commit_req = 0;
        expect_at(0, "oor_err_clr", S_ERR, 0);
        expect_at(0, "nop_done", S_DONE, 1);
        expect_at(0, "nop_busy", S_BUSY, 0);
        expect_at(0, "nop_cfg", S_CFG, 32'h00e50);
        tick;
        // force_off while ch3 pending and ch0 on
        wr(0, 4'b1101);
        tick; wr(3, 4'b1010); commit_req = 1;
        tick; wr_valid = 0; commit_req = 0; sync_evt = 5'b00001;
        expect_at(0, "f_busy", S_BUSY, 1);
        tick; sync_evt = 0;
        expect_at(0, "f_cfg", S_CFG, 32'h00e5d);
        expect_at(0, "f_on", S_ON, 32'b00101);
        force_off = 1;
        expect_at(0, "f_rdy_low", S_RDY, 0);
        tick; force_off = 0; commit_req = 1;
        expect_at(0, "f_on0", S_ON, 0);
        expect_at(0, "f_abort", S_ABT, 1);
        expect_at(0, "f_done", S_DONE, 0);
        expect_at(0, "f_busy0", S_BUSY, 0);
        expect_at(0, "f_rdy", S_RDY, 1);
        expect_at(0, "f_cfg_kill", S_CFG, 32'h00655);
        expect_at(1, "f_abort1", S_ABT, 0);
        expect_at(1, "f_done1", S_DONE, 0);
        tick; commit_req = 0; sync_evt = 5'b01000;
        expect_at(0, "rc_busy", S_BUSY, 1);
        tick; sync_evt = 0;
        expect_at(0, "rc_cfg", S_CFG, 32'h02655);
        expect_at(0, "rc_on", S_ON, 0);
        expect_at(1, "rc_done", S_DONE, 1);
        tick(2);
        // reset in the middle of a commit
        wr(4, 4'b1111); commit_req = 1;
        tick; wr_valid = 0; commit_req = 0;
        expect_at(0, "mr_busy", S_BUSY, 1);
        tick; rst_n = 0;
        expect_at(0, "mr_cfg", S_CFG, 0);
        expect_at(0, "mr_busy0", S_BUSY, 0);
        expect_at(0, "mr_rdy", S_RDY, 1);
        tick; rst_n = 1;
        expect_at(1, "mr_done", S_DONE, 0);
        expect_at(1, "mr_abort", S_ABT, 0);
        expect_at(1, "mr_cfg1", S_CFG, 0);
        tick;
`ifdef PWM_CFGREG_COMMIT_TIMEOUT_EN
        wr(1, 4'b1101); commit_req = 1;
        expect_at(8, "to_busy", S_BUSY, 1);
        expect_at(8, "to_cfg0", S_CFG, 0);
        expect_at(8, "to_tmo0", S_TMO, 0);
        expect_at(9, "to_cfg", S_CFG, 32'h000d0);
        expect_at(9, "to_done", S_DONE, 1);
        expect_at(9, "to_tmo", S_TMO, 1);
        expect_at(10, "to_tmo_clr", S_TMO, 0);
        expect_at(10, "to_done_clr", S_DONE, 0);
        tick; wr_valid = 0; commit_req = 0;
`endif
        tick(12);
        if (sb.size() != 0) begin
            $display("FAIL scoreboard: %0d expectations never reached", sb.size());
            n_errors += sb.size();
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
